inst_fetch_sram: RTL and testbench

Instruction-side responder for the IF-stage fetch request (`pc` + `ce`). It accepts the fetch address, runs a fixed-wait asynchronous-SRAM read on the base RAM, and returns the 32-bit instruction. It holds the pipeline through `stallreq_o` until the word is available. A one-entry fetch buffer returns a repeated address during a stall without a second SRAM access. The block sits between the PC register, the stall controller and the base-RAM pins.

---
 rtl/gemips_pkg.sv | 17 +
 rtl/inst_fetch_sram_fetch_buf.sv | 48 ++++
 rtl/inst_fetch_sram.sv | 119 +++++++++++
 tb/tb_inst_fetch_sram.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/gemips_pkg.sv
// ---------------------------------------------------------------------------
// gemips_pkg: constants shared by the instruction-fetch blocks.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package gemips_pkg;

  localparam int          INST_WAIT_CYCLES = 2;

  localparam logic [0:0]  IF_IDLE = 1'b0;
  localparam logic [0:0]  IF_WAIT = 1'b1;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/inst_fetch_sram_fetch_buf.sv
// ---------------------------------------------------------------------------
// fetch_buf: one-entry tag/data buffer with hit compare and invalidate.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_buf #(
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_ce,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_wr,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [31:0]       i_wr_data,
  input  logic              i_invalidate,
  output logic              o_hit,
  output logic [31:0]       o_data
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_data;

  // A capture coinciding with an invalidate still writes tag/data, but leaves the entry invalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      if (i_wr) begin
        r_addr <= i_wr_addr;
        r_data <= i_wr_data;
      end
      if (i_invalidate)
        r_valid <= 1'b0;
      else if (i_wr)
        r_valid <= 1'b1;
    end
  end

  assign o_hit  = i_ce && r_valid && (r_addr == i_addr);
  assign o_data = r_data;

endmodule

`default_nettype wire

// File: rtl/inst_fetch_sram.sv
// ---------------------------------------------------------------------------
// inst_fetch_sram: IF-stage fetch responder driving a fixed-wait async SRAM.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module inst_fetch_sram
  import gemips_pkg::*;
#(
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = INST_WAIT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pc_i,
  input  logic              ce_i,
  input  logic              flush_i,
  input  logic              invalidate_i,
  output logic [31:0]       inst_o,
  output logic              inst_valid_o,
  output logic              stallreq_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic              sram_ce_n_o,
  output logic              sram_oe_n_o,
  output logic              sram_we_n_o,
  output logic [3:0]        sram_be_n_o,
  input  logic [31:0]       sram_data_i
);

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic [ADDR_W-1:0] r_req_addr;
  logic [3:0]        r_cnt;

  logic [ADDR_W-1:0] w_pc_word;
  logic              w_hit;
  logic [31:0]       w_buf_data;
  logic              w_start;
  logic              w_capture;
  logic              w_unused_pc;

  assign w_pc_word   = pc_i[ADDR_W+1:2];
  assign w_unused_pc = ^{pc_i[31:ADDR_W+2], pc_i[1:0]};

  assign w_start   = (r_state == IF_IDLE) && ce_i && !w_hit && !flush_i;
  assign w_capture = (r_state == IF_WAIT) && (r_cnt == 4'd0) && !flush_i;

  fetch_buf #(
    .ADDR_W (ADDR_W)
  ) u_fetch_buf (
    .clk          (clk),
    .rst          (rst),
    .i_ce         (ce_i),
    .i_addr       (w_pc_word),
    .i_wr         (w_capture),
    .i_wr_addr    (r_req_addr),
    .i_wr_data    (sram_data_i),
    .i_invalidate (invalidate_i),
    .o_hit        (w_hit),
    .o_data       (w_buf_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IF_IDLE;
      r_req_addr <= '0;
      r_cnt      <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_req_addr <= w_pc_word;
        r_cnt      <= 4'(WAIT_CYCLES - 1);
      end else if ((r_state == IF_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IF_IDLE: if (w_start) w_state_nxt = IF_WAIT;
      IF_WAIT: if (flush_i || (r_cnt == 4'd0)) w_state_nxt = IF_IDLE;
      default: w_state_nxt = IF_IDLE;
    endcase
  end

  // Strobes depend only on r_state so the SRAM pins never glitch with pc_i.
  always_comb begin
    inst_o       = NOP_INST;
    inst_valid_o = 1'b0;
    stallreq_o   = 1'b0;
    sram_ce_n_o  = 1'b1;
    sram_oe_n_o  = 1'b1;
    sram_be_n_o  = 4'hF;
    case (r_state)
      IF_IDLE: begin
        if (w_hit) begin
          inst_o       = w_buf_data;
          inst_valid_o = 1'b1;
        end else if (ce_i) begin
          stallreq_o = 1'b1;
        end
      end
      IF_WAIT: begin
        stallreq_o  = 1'b1;
        sram_ce_n_o = 1'b0;
        sram_oe_n_o = 1'b0;
        sram_be_n_o = 4'h0;
      end
      default: ;
    endcase
  end

  assign sram_addr_o = r_req_addr;
  assign sram_we_n_o = 1'b1;

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_sram.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch_sram: directed + random fetch checks against a latency/buffer model.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_inst_fetch_sram;

  localparam int AW = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc  = 32'h0;
  logic        ce  = 1'b0;
  logic        flush = 1'b0;
  logic        inv = 1'b0;
  logic        sel = 1'b0;

  logic [31:0] mem [0:63];

  logic [31:0] inst2, inst1, sd2, sd1;
  logic        valid2, valid1, stall2, stall1;
  logic [AW-1:0] addr2, addr1;
  logic        ce_n2, ce_n1, oe_n2, oe_n1, we_n2, we_n1;
  logic [3:0]  be_n2, be_n1;

  logic [31:0] inst;
  logic        valid, stall, ce_n, oe_n, we_n;
  logic [AW-1:0] addr;
  logic [3:0]  be_n;

  int checks = 0;
  int failures = 0;
  bit mvalid = 1'b0;
  logic [AW-1:0] maddr = '0;

  always #5 clk = ~clk;

  assign sd2 = (!ce_n2 && !oe_n2) ? mem[addr2[5:0]] : 32'hDEAD_BEEF;
  assign sd1 = (!ce_n1 && !oe_n1) ? mem[addr1[5:0]] : 32'hDEAD_BEEF;

  assign inst  = sel ? inst1  : inst2;
  assign valid = sel ? valid1 : valid2;
  assign stall = sel ? stall1 : stall2;
  assign addr  = sel ? addr1  : addr2;
  assign ce_n  = sel ? ce_n1  : ce_n2;
  assign oe_n  = sel ? oe_n1  : oe_n2;
  assign we_n  = sel ? we_n1  : we_n2;
  assign be_n  = sel ? be_n1  : be_n2;

  inst_fetch_sram #(.ADDR_W(AW), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .pc_i(pc), .ce_i(ce), .flush_i(flush), .invalidate_i(inv),
    .inst_o(inst2), .inst_valid_o(valid2), .stallreq_o(stall2), .sram_addr_o(addr2),
    .sram_ce_n_o(ce_n2), .sram_oe_n_o(oe_n2), .sram_we_n_o(we_n2), .sram_be_n_o(be_n2),
    .sram_data_i(sd2)
  );

  inst_fetch_sram #(.ADDR_W(AW), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .pc_i(pc), .ce_i(ce), .flush_i(flush), .invalidate_i(inv),
    .inst_o(inst1), .inst_valid_o(valid1), .stallreq_o(stall1), .sram_addr_o(addr1),
    .sram_ce_n_o(ce_n1), .sram_oe_n_o(oe_n1), .sram_we_n_o(we_n1), .sram_be_n_o(be_n1),
    .sram_data_i(sd1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int wcur();
    return sel ? 1 : 2;
  endfunction

  task automatic chk_idle_quiet(input string tag);
    chk({tag, "_inst"},  inst,  32'h0);
    chk({tag, "_valid"}, {31'b0, valid}, 32'h0);
    chk({tag, "_stall"}, {31'b0, stall}, 32'h0);
    chk({tag, "_ce_n"},  {31'b0, ce_n},  32'h1);
    chk({tag, "_oe_n"},  {31'b0, oe_n},  32'h1);
    chk({tag, "_we_n"},  {31'b0, we_n},  32'h1);
    chk({tag, "_be_n"},  {28'b0, be_n},  32'hF);
  endtask

  // One fetch under the stall contract: a miss stalls W+1 cycles with W strobe cycles, a hit none.
  task automatic fetch(input logic [31:0] pc_v, input bit exp_hit);
    int stalls = 0;
    int strobes = 0;
    bit done = 1'b0;
    logic [AW-1:0] word;
    word = pc_v[AW+1:2];
    @(negedge clk);
    pc = pc_v; ce = 1'b1; flush = 1'b0; inv = 1'b0;
    #1;
    for (int n = 0; n < 40 && !done; n++) begin
      if (n > 0) begin
        @(negedge clk);
        #1;
      end
      if (valid) begin
        done = 1'b1;
      end else begin
        if (stall) stalls++;
        if (!ce_n) begin
          strobes++;
          chk("wait_addr", {12'b0, addr}, {12'b0, word});
          chk("wait_oe_n", {31'b0, oe_n}, 32'h0);
          chk("wait_be_n", {28'b0, be_n}, 32'h0);
        end
      end
    end
    chk("fetch_done", {31'b0, done}, 32'h1);
    chk("stall_cycles", stalls, exp_hit ? 0 : wcur() + 1);
    chk("strobe_cycles", strobes, exp_hit ? 0 : wcur());
    chk("inst_data", inst, mem[word[5:0]]);
    chk("stall_at_deliver", {31'b0, stall}, 32'h0);
    chk("ce_n_at_deliver", {31'b0, ce_n}, 32'h1);
    mvalid = 1'b1;
    maddr  = word;
  endtask

  initial begin
    logic [AW-1:0] w;
    logic [31:0]   pc_v;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'h2408_0001;

    // reset asserted mid-cycle
    @(negedge clk);
    #3 rst = 1'b1;
    #1 chk_idle_quiet("reset");
    chk("reset_addr", {12'b0, addr}, 32'h0);
    @(negedge clk);
    #3 rst = 1'b0;

    // first miss, then repeated address during stall window
    fetch(32'h8000_0000, 1'b0);
    for (int i = 0; i < 4; i++) fetch(32'h8000_0000, 1'b1);

    // flush in first WAIT cycle
    @(negedge clk);
    pc = 32'h8000_0004; ce = 1'b1;
    #1 chk("miss_stall_comb", {31'b0, stall}, 32'h1);
    @(negedge clk);
    flush = 1'b1;
    #1 chk("flush_in_wait_ce_n", {31'b0, ce_n}, 32'h0);
    @(negedge clk);
    flush = 1'b0; ce = 1'b0;
    #1 chk_idle_quiet("after_flush");
    fetch(32'h8000_0000, mvalid && maddr == 20'd0);
    fetch(32'h8000_0004, 1'b0);

    // invalidate on the final WAIT cycle
    @(negedge clk);
    pc = 32'h8000_0008; ce = 1'b1;
    for (int k = 1; k <= wcur(); k++) begin
      @(negedge clk);
      if (k == wcur()) inv = 1'b1;
    end
    #1 chk("inv_final_wait_ce_n", {31'b0, ce_n}, 32'h0);
    mvalid = 1'b0;
    fetch(32'h8000_0008, 1'b0);

    // ce low: nothing presented even for a buffered address
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ce = 1'b0;
      pc = (i == 0) ? 32'h8000_0008 : (32'h8000_0000 | ($urandom & 32'hFC));
      #1 chk_idle_quiet("ce_low");
    end

    // reset in the middle of an access
    @(negedge clk);
    pc = 32'h8000_0010; ce = 1'b1;
    @(negedge clk);
    #1 chk("pre_reset_ce_n", {31'b0, ce_n}, 32'h0);
    #2 rst = 1'b1;
    #1 chk("midreset_ce_n", {31'b0, ce_n}, 32'h1);
    chk("midreset_oe_n", {31'b0, oe_n}, 32'h1);
    chk("midreset_be_n", {28'b0, be_n}, 32'hF);
    @(negedge clk);
    ce = 1'b0;
    #3 rst = 1'b0;
    mvalid = 1'b0;

    // random fetches over a small address window with occasional invalidates
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(negedge clk);
        ce = 1'b0; inv = 1'b1;
        #1 chk("inv_pulse_valid", {31'b0, valid}, 32'h0);
        mvalid = 1'b0;
      end
      w = AW'($urandom_range(0, 7));
      pc_v = 32'h8000_0000 | (32'(w) << 2) | 32'($urandom_range(0, 3));
      fetch(pc_v, mvalid && (maddr == w));
    end

    // WAIT_CYCLES=1 instance: sequential sweep
    @(negedge clk);
    ce = 1'b0; inv = 1'b0;
    #3 rst = 1'b1;
    @(negedge clk);
    sel = 1'b1;
    #3 rst = 1'b0;
    mvalid = 1'b0;
    for (int i = 0; i < 16; i++) fetch(32'h8000_0000 + 32'(i * 4), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
